// File: rtl/bv_inv_solver.sv
// Bit-serial inverse solver: finds x with (x op s) == t for op in {OR, AND, XOR, ADD},
// processing BPC bits per cycle LSB first, and flags whether any such x exists.
module bv_inv_solver #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned BPC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_s,
  input  logic [WIDTH-1:0] in_t,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_x,
  output logic             out_inv
);

  localparam int unsigned N    = WIDTH / BPC;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  localparam logic [1:0] OpOr  = 2'b00;
  localparam logic [1:0] OpAnd = 2'b01;
  localparam logic [1:0] OpXor = 2'b10;
  localparam logic [1:0] OpAdd = 2'b11;

  if (BPC == 0 || WIDTH == 0 || (WIDTH % BPC) != 0) begin : g_param_check
    $error("bv_inv_solver: WIDTH must be a nonzero multiple of BPC");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] t_q, t_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             fail_q, fail_d;

  logic [BPC-1:0]   chunk_x;
  logic             borrow_c;
  logic             fail_c;

  // Per-chunk bit rules on the low BPC bits of the shifting operand registers.
  always_comb begin
    chunk_x  = '0;
    fail_c   = fail_q;
    borrow_c = borrow_q;
    for (int i = 0; i < int'(BPC); i++) begin
      unique case (op_q)
        OpOr: begin
          fail_c     = fail_c | (s_q[i] & ~t_q[i]);
          chunk_x[i] = t_q[i] & ~s_q[i];
        end
        OpAnd: begin
          fail_c     = fail_c | (~s_q[i] & t_q[i]);
          chunk_x[i] = t_q[i];
        end
        OpXor: chunk_x[i] = t_q[i] ^ s_q[i];
        OpAdd: begin
          // x = t - s: ripple borrow through the chunk, carried across chunks in borrow_q
          chunk_x[i] = t_q[i] ^ s_q[i] ^ borrow_c;
          borrow_c   = (~t_q[i] & s_q[i]) | (~(t_q[i] ^ s_q[i]) & borrow_c);
        end
      endcase
    end
  end

  // Next-state: accept in IDLE, one chunk per RUN cycle, hold in DONE until consumed.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    s_d      = s_q;
    t_d      = t_q;
    x_d      = x_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    fail_d   = fail_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d     = in_op;
          s_d      = in_s;
          t_d      = in_t;
          x_d      = '0;
          cnt_d    = '0;
          borrow_d = 1'b0;
          fail_d   = 1'b0;
          state_d  = StRun;
        end
      end
      StRun: begin
        // Operands shift down so the current chunk is always at bit 0; results enter at
        // the top so chunk k lands at bits k*BPC.. after all N shifts.
        s_d      = s_q >> BPC;
        t_d      = t_q >> BPC;
        x_d      = (x_q >> BPC) | (WIDTH'(chunk_x) << (WIDTH - BPC));
        borrow_d = borrow_c;
        fail_d   = fail_c;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= 2'b00;
      s_q      <= '0;
      t_q      <= '0;
      x_q      <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      s_q      <= s_d;
      t_q      <= t_d;
      x_q      <= x_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      fail_q   <= fail_d;
    end
  end

  // Outputs decode from state; x is only exposed when a valid witness exists.
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    out_inv   = out_valid & ~fail_q;
    out_x     = out_inv ? x_q : '0;
  end

endmodule

// File: tb/tb_bv_inv_solver.sv
// Self-checking bench: WIDTH=4/BPC=1 and WIDTH=8/BPC=2 instances, table vectors,
// hand-written corner sequences and a randomized sweep with a scoreboard.
module tb_bv_inv_solver;

  localparam logic [1:0] OpOr  = 2'b00;
  localparam logic [1:0] OpAnd = 2'b01;
  localparam logic [1:0] OpXor = 2'b10;
  localparam logic [1:0] OpAdd = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid4, in_ready4, out_valid4, out_ready4, out_inv4;
  logic [1:0] in_op4;
  logic [3:0] in_s4, in_t4, out_x4;
  logic       in_valid8, in_ready8, out_valid8, out_ready8, out_inv8;
  logic [1:0] in_op8;
  logic [7:0] in_s8, in_t8, out_x8;

  bv_inv_solver #(.WIDTH(4), .BPC(1)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_op(in_op4), .in_s(in_s4), .in_t(in_t4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_x(out_x4), .out_inv(out_inv4)
  );

  bv_inv_solver #(.WIDTH(8), .BPC(2)) u_dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_op(in_op8), .in_s(in_s8), .in_t(in_t8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_x(out_x8), .out_inv(out_inv8)
  );

  typedef struct {
    logic [7:0] x;
    logic       inv;
  } res_t;

  typedef struct {
    logic [1:0] op;
    logic [3:0] s;
    logic [3:0] t;
    logic [3:0] x;
    logic       inv;
    int         hold;
  } vec_t;

  res_t sb4[$];
  res_t sb8[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] apply_op(input logic [1:0] op, input logic [7:0] x,
                                          input logic [7:0] s, input logic [7:0] mask);
    case (op)
      OpOr:    return (x | s) & mask;
      OpAnd:   return (x & s) & mask;
      OpXor:   return (x ^ s) & mask;
      default: return (x + s) & mask;
    endcase
  endfunction

  function automatic res_t model(input logic [1:0] op, input logic [7:0] s, input logic [7:0] t,
                                 input logic [7:0] mask);
    res_t r;
    r.inv = 1'b1;
    case (op)
      OpOr:  begin r.inv = ((s & ~t & mask) == 8'h00); r.x = t & ~s & mask; end
      OpAnd: begin r.inv = ((t & ~s & mask) == 8'h00); r.x = t & mask; end
      OpXor: r.x = (t ^ s) & mask;
      default: r.x = (t - s) & mask;
    endcase
    if (!r.inv) r.x = 8'h00;
    return r;
  endfunction

  // A claimed witness must satisfy the equation; a claimed failure must have no solution at all.
  task automatic check_witness(input string name, input logic [1:0] op, input logic [7:0] s,
                               input logic [7:0] t, input logic [7:0] x, input logic inv,
                               input logic [7:0] mask);
    int nsol;
    nsol = 0;
    if (inv) begin
      check($sformatf("%s witness", name), 32'(apply_op(op, x, s, mask)), 32'(t & mask));
    end else begin
      for (int c = 0; c <= int'(mask); c++) begin
        if (apply_op(op, 8'(c), s, mask) == (t & mask)) nsol++;
      end
      check($sformatf("%s no_solution", name), 32'(nsol), 32'd0);
    end
  endtask

  task automatic solve4(input string name, input logic [1:0] op, input logic [3:0] s,
                        input logic [3:0] t, input res_t e, input int hold);
    int         lat;
    res_t       got;
    logic [3:0] x_snap;
    logic       inv_snap;
    @(negedge clk);
    lat = 0;
    while (!in_ready4 && lat < 20) begin @(negedge clk); lat++; end
    check($sformatf("%s in_ready_idle", name), 32'(in_ready4), 32'd1);
    in_op4 = op; in_s4 = s; in_t4 = t; in_valid4 = 1'b1;
    @(posedge clk);
    sb4.push_back(e);
    #1;
    lat = 0;
    // in_valid stays high with garbage operands: must be ignored while busy
    while (!out_valid4 && lat < 20) begin
      in_s4 = 4'($urandom); in_t4 = 4'($urandom); in_op4 = 2'($urandom);
      @(posedge clk); #1; lat++;
    end
    check($sformatf("%s latency", name), 32'(lat), 32'd4);
    check($sformatf("%s in_ready_busy", name), 32'(in_ready4), 32'd0);
    x_snap = out_x4; inv_snap = out_inv4;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check($sformatf("%s hold%0d x", name, i), 32'(out_x4), 32'(x_snap));
      check($sformatf("%s hold%0d inv", name, i), 32'(out_inv4), 32'(inv_snap));
      check($sformatf("%s hold%0d valid", name, i), 32'(out_valid4), 32'd1);
      check($sformatf("%s hold%0d in_ready", name, i), 32'(in_ready4), 32'd0);
    end
    if (sb4.size() == 0) begin
      check($sformatf("%s scoreboard_nonempty", name), 32'd0, 32'd1);
    end else begin
      got = sb4.pop_front();
      check($sformatf("%s out_x", name), 32'(out_x4), 32'(got.x));
      check($sformatf("%s out_inv", name), 32'(out_inv4), 32'(got.inv));
    end
    check_witness(name, op, 8'(s), 8'(t), 8'(out_x4), out_inv4, 8'h0F);
    in_valid4 = 1'b0; out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
    check($sformatf("%s in_ready_after", name), 32'(in_ready4), 32'd1);
    check($sformatf("%s valid_after", name), 32'(out_valid4), 32'd0);
  endtask

  task automatic solve8(input string name, input logic [1:0] op, input logic [7:0] s,
                        input logic [7:0] t, input res_t e);
    int   lat;
    res_t got;
    @(negedge clk);
    lat = 0;
    while (!in_ready8 && lat < 20) begin @(negedge clk); lat++; end
    check($sformatf("%s in_ready_idle", name), 32'(in_ready8), 32'd1);
    in_op8 = op; in_s8 = s; in_t8 = t; in_valid8 = 1'b1;
    @(posedge clk);
    sb8.push_back(e);
    #1;
    in_valid8 = 1'b0; in_s8 = 8'($urandom); in_t8 = 8'($urandom);
    lat = 0;
    while (!out_valid8 && lat < 20) begin @(posedge clk); #1; lat++; end
    check($sformatf("%s latency", name), 32'(lat), 32'd4);
    if (sb8.size() == 0) begin
      check($sformatf("%s scoreboard_nonempty", name), 32'd0, 32'd1);
    end else begin
      got = sb8.pop_front();
      check($sformatf("%s out_x", name), 32'(out_x8), 32'(got.x));
      check($sformatf("%s out_inv", name), 32'(out_inv8), 32'(got.inv));
    end
    check_witness(name, op, s, t, out_x8, out_inv8, 8'hFF);
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    check($sformatf("%s in_ready_after", name), 32'(in_ready8), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vt[6];
    logic [1:0] rop;
    logic [7:0] rs, rt;
    res_t       e;

    vt[0] = '{OpOr,  4'b0101, 4'b0111, 4'b0010, 1'b1, 5};
    vt[1] = '{OpOr,  4'b0101, 4'b0011, 4'b0000, 1'b0, 0};
    vt[2] = '{OpAnd, 4'b0110, 4'b0100, 4'b0100, 1'b1, 0};
    vt[3] = '{OpAnd, 4'b0110, 4'b1000, 4'b0000, 1'b0, 0};
    vt[4] = '{OpAdd, 4'b1011, 4'b0010, 4'b0111, 1'b1, 0};
    vt[5] = '{OpXor, 4'b1100, 4'b1010, 4'b0110, 1'b1, 0};

    rst = 1'b1;
    in_valid4 = 1'b0; in_op4 = 2'b00; in_s4 = '0; in_t4 = '0; out_ready4 = 1'b0;
    in_valid8 = 1'b0; in_op8 = 2'b00; in_s8 = '0; in_t8 = '0; out_ready8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("reset in_ready4", 32'(in_ready4), 32'd1);
    check("reset out_valid4", 32'(out_valid4), 32'd0);
    check("reset out_x4", 32'(out_x4), 32'd0);
    check("reset out_inv4", 32'(out_inv4), 32'd0);
    check("reset in_ready8", 32'(in_ready8), 32'd1);
    check("reset out_valid8", 32'(out_valid8), 32'd0);

    for (int i = 0; i < 6; i++) begin
      e.x = {4'h0, vt[i].x};
      e.inv = vt[i].inv;
      solve4($sformatf("vec%0d", i), vt[i].op, vt[i].s, vt[i].t, e, vt[i].hold);
    end

    // Reset in the middle of RUN after two chunks discards the solve.
    @(negedge clk);
    in_op4 = OpAdd; in_s4 = 4'b1011; in_t4 = 4'b0010; in_valid4 = 1'b1;
    @(posedge clk); #1 in_valid4 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("midrun_rst in_ready", 32'(in_ready4), 32'd1);
    check("midrun_rst out_valid", 32'(out_valid4), 32'd0);
    check("midrun_rst out_x", 32'(out_x4), 32'd0);
    check("midrun_rst out_inv", 32'(out_inv4), 32'd0);
    e.x = 8'h0F; e.inv = 1'b1;
    solve4("fresh_add", OpAdd, 4'b0001, 4'b0000, e, 0);

    // Wide instance: borrow across chunks of 2 bits.
    e.x = 8'hFF; e.inv = 1'b1;
    solve8("w8_add", OpAdd, 8'h01, 8'h00, e);

    for (int i = 0; i < 20; i++) begin
      rop = 2'($urandom); rs = 8'($urandom_range(15)); rt = 8'($urandom_range(15));
      solve4($sformatf("rnd4_%0d", i), rop, rs[3:0], rt[3:0], model(rop, rs, rt, 8'h0F), 0);
    end

    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom); rs = 8'($urandom); rt = 8'($urandom);
      // Bias OR/AND toward solvable targets so both outcomes get exercised.
      if ($urandom_range(1) == 1) begin
        if (rop == OpOr) rt = rt | rs;
        if (rop == OpAnd) rt = rt & rs;
      end
      solve8($sformatf("rnd8_%0d", i), rop, rs, rt, model(rop, rs, rt, 8'hFF));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
